// File: rtl/adder_tree_seq.sv
// Sequential group accumulator over a 14-lane signed adder tree, with a valid/ready handshake on both sides.
// Optional macro ADDER_TREE_SAT_EN makes accumulation saturate; by default accumulation wraps mod 2^16.

module adder_tree_14 (
  input  logic signed [15:0] psum [0:13],
  output logic signed [15:0] sum
);
  logic signed [15:0] lvl1 [0:6];
  logic signed [15:0] lvl2 [0:3];
  logic signed [15:0] lvl3 [0:1];

  // Balanced 14 -> 7 -> 4 -> 2 -> 1 reduction; every add wraps at 16 bits.
  always_comb begin
    for (int i = 0; i < 7; i++) lvl1[i] = psum[2*i] + psum[2*i+1];
    for (int i = 0; i < 3; i++) lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    lvl2[3] = lvl1[6];
    lvl3[0] = lvl2[0] + lvl2[1];
    lvl3[1] = lvl2[2] + lvl2[3];
    sum     = lvl3[0] + lvl3[1];
  end
endmodule

module adder_tree_seq (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [7:0]         cfg_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_data [0:13],
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_sum,
  output logic               busy
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         len_q, len_d;

  logic signed [15:0] tree_sum;
  logic signed [15:0] acc_sum;
  logic [7:0]         first_len;
  logic               accept;

  adder_tree_14 u_tree (
    .psum (in_data),
    .sum  (tree_sum)
  );

`ifdef ADDER_TREE_SAT_EN
  logic signed [16:0] acc_wide;

  // Overflow shows up as disagreement between the two top bits of the 17-bit sum.
  always_comb begin
    acc_wide = {acc_q[15], acc_q} + {tree_sum[15], tree_sum};
    if (acc_wide[16] != acc_wide[15])
      acc_sum = acc_wide[16] ? 16'sh8000 : 16'sh7fff;
    else
      acc_sum = acc_wide[15:0];
  end
`else
  assign acc_sum = acc_q + tree_sum;
`endif

  assign first_len = (cfg_len == 8'd0) ? 8'd1 : cfg_len;

  // Reset and flush both block acceptance combinationally so no beat slips in.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && !flush) begin
      case (state_q)
        S_IDLE, S_ACCUM: in_ready = 1'b1;
        S_OUT:           in_ready = out_ready;
        default:         in_ready = 1'b0;
      endcase
    end
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = rst_n && !flush && (state_q == S_OUT);
  assign out_sum   = rst_n ? acc_q : 16'sd0;
  assign busy      = rst_n && (state_q != S_IDLE);

  // NOTE: every _d gets its default from the current state first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          len_d   = first_len;
          acc_d   = tree_sum;
          cnt_d   = 8'd1;
          state_d = (first_len == 8'd1) ? S_OUT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (accept) begin
            len_d   = first_len;
            acc_d   = tree_sum;
            cnt_d   = 8'd1;
            state_d = (first_len == 8'd1) ? S_OUT : S_ACCUM;
          end else begin
            acc_d   = 16'sd0;
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      acc_d   = 16'sd0;
      cnt_d   = 8'd0;
      state_d = S_IDLE;
    end
  end

  // NOTE: reset is sampled synchronously here, and all state updates use non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 16'sd0;
      cnt_q   <= 8'd0;
      len_q   <= 8'd1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end
endmodule

// File: tb/tb_adder_tree_seq.sv
// Self-checking bench for adder_tree_seq: a beat-level scoreboard plus directed protocol checks.
// The expected accumulation mode follows the ADDER_TREE_SAT_EN macro.
`timescale 1ns/1ps

module tb_adder_tree_seq;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic [7:0]         cfg_len = 8'd1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] in_data [0:13];
  logic               in_ready, out_valid, busy;
  logic signed [15:0] out_sum;

  int checks = 0;
  int passes = 0;
  logic signed [15:0] sb [$];
  int m_cnt = 0;
  int m_len = 1;
  int m_acc = 0;

  always #5 clk = ~clk;

  adder_tree_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else passes++;
  endtask

  function automatic int wrap16(input int x);
    logic signed [15:0] r;
    r = x[15:0];
    return int'(r);
  endfunction

  function automatic int fold(input int x);
`ifdef ADDER_TREE_SAT_EN
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
`else
    return wrap16(x);
`endif
  endfunction

  function automatic int lane_total();
    int s = 0;
    for (int i = 0; i < 14; i++) s += int'(in_data[i]);
    return wrap16(s);
  endfunction

  task automatic set_all(input int v);
    for (int i = 0; i < 14; i++) in_data[i] = 16'(v);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 14; i++) in_data[i] = 16'(i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: retire results on output handshakes, build expected group sums from accepted beats.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      m_cnt = 0;
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_spurious", int'(out_valid), 0);
        else check("sb_sum", int'(out_sum), int'(sb.pop_front()));
      end
      if (in_valid && in_ready) begin
        if (m_cnt == 0) begin
          m_len = (cfg_len == 8'd0) ? 1 : int'(cfg_len);
          m_acc = lane_total();
        end else begin
          m_acc = fold(m_acc + lane_total());
        end
        m_cnt++;
        if (m_cnt == m_len) begin
          sb.push_back(16'(m_acc));
          m_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    set_all(0);
    // Reset values
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_busy", int'(busy), 0);
    step();
    rst_n = 1'b1;

    // Single-beat groups back to back
    cfg_len = 8'd1; set_all(1); in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("len1_ready", int'(in_ready), 1);
      if (i > 0) begin
        check("len1_valid", int'(out_valid), 1);
        check("len1_sum", int'(out_sum), 14);
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("len1_last_valid", int'(out_valid), 1);
    step();
    @(negedge clk);
    check("len1_idle_valid", int'(out_valid), 0);
    check("len1_idle_busy", int'(busy), 0);

    // Three-beat ramp; cfg_len change mid-group must be ignored; next group starts in the OUT cycle
    step();
    cfg_len = 8'd3; set_ramp(); in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("len3_ready", int'(in_ready), 1);
      step();
      cfg_len = 8'd1;
    end
    set_all(1);
    @(negedge clk);
    check("len3_valid", int'(out_valid), 1);
    check("len3_sum", int'(out_sum), 273);
    check("len3_nobubble_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("len3_next_valid", int'(out_valid), 1);
    step();

    // Back-pressure: result held, no beat taken while out_ready is low
    cfg_len = 8'd2; set_all(5); in_valid = 1'b1; out_ready = 1'b0;
    step(); step();
    set_all(7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_sum", int'(out_sum), 140);
      check("stall_ready", int'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", int'(in_ready), 1);
    step(); step();
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_next_sum", int'(out_sum), 196);
    step();
    @(negedge clk);
    check("stall_idle_valid", int'(out_valid), 0);

    // Flush mid-group
    cfg_len = 8'd4; set_all(3); in_valid = 1'b1;
    step(); step();
    flush = 1'b1;
    @(negedge clk);
    check("flush_ready", int'(in_ready), 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flush_busy", int'(busy), 0);
      check("flush_valid", int'(out_valid), 0);
      step();
    end
    cfg_len = 8'd1; set_all(2); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_next_sum", int'(out_sum), 28);
    step();

    // Accumulator overflow, positive and negative
    cfg_len = 8'd4; set_all(1000); in_valid = 1'b1;
    repeat (4) step();
    in_valid = 1'b0;
    @(negedge clk);
`ifdef ADDER_TREE_SAT_EN
    check("ovf_pos_sum", int'(out_sum), 32767);
`else
    check("ovf_pos_sum", int'(out_sum), -9536);
`endif
    step();
    cfg_len = 8'd2; set_all(-2000); in_valid = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    @(negedge clk);
`ifdef ADDER_TREE_SAT_EN
    check("ovf_neg_sum", int'(out_sum), -32768);
`else
    check("ovf_neg_sum", int'(out_sum), 9536);
`endif
    step();

    // Reset in the middle of a group
    cfg_len = 8'd8; set_all(9); in_valid = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", int'(in_ready), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_sum", int'(out_sum), 0);
    check("midrst_busy", int'(busy), 0);
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("postrst_busy", int'(busy), 0);
    cfg_len = 8'd1; set_all(1); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("postrst_valid", int'(out_valid), 1);
    check("postrst_sum", int'(out_sum), 14);
    step();

    // cfg_len of 0 behaves as 1; cfg_len of 255 is the longest group
    cfg_len = 8'd0; set_all(4); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("len0_valid", int'(out_valid), 1);
    check("len0_sum", int'(out_sum), 56);
    step();
    cfg_len = 8'd255; set_all(1); in_valid = 1'b1;
    repeat (254) step();
    @(negedge clk);
    check("len255_not_done", int'(out_valid), 0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("len255_valid", int'(out_valid), 1);
    check("len255_sum", int'(out_sum), 3570);
    step();

    // Flush while a result is pending drops it
    cfg_len = 8'd1; set_all(6); in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", int'(out_valid), 0);
    check("flush_out_busy", int'(busy), 0);
    step();

    // Randomised traffic, checked by the scoreboard
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 60) == 0;
      cfg_len   = 8'($urandom_range(0, 5));
      for (int i = 0; i < 14; i++) in_data[i] = 16'(int'($urandom_range(0, 6000)) - 3000);
      step();
    end
    flush = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 300 && m_cnt != 0; n++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (5) step();
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("final_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/adder_tree_seq.md
ADDER_TREE_SEQ -- requirements
Module: adder_tree_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: flush  in  1  abort current group, synchronous.
REQ-004 SHALL have ports: cfg_len  in  8  beats per group; 0 treated as 1.
REQ-005 SHALL have ports: in_valid  in  1  beat offered.
REQ-006 SHALL have ports: in_ready  out  1  beat accepted when in_valid&in_ready.
REQ-007 SHALL have ports: in_data  in  16 x [0:13]  fourteen signed psums per beat.
REQ-008 SHALL have ports: out_valid  out  1  group result available.
REQ-009 SHALL have ports: out_ready  in  1  consumer takes result when out_valid&out_ready.
REQ-010 SHALL have ports: out_sum  out  16  signed group total.
REQ-011 SHALL have ports: busy  out  1  high in ACCUM or OUT.

Function
REQ-012 SHALL instantiate one adder_tree_14 combinationally on in_data; tree sum wraps mod 2^16.
REQ-013 SHALL implement FSM IDLE, ACCUM, OUT; one accumulator acc[15:0], beat counter cnt[7:0], latched length len[7:0].
REQ-014 IDLE: in_ready=1; on accept, len<=max(cfg_len,1), acc<=tree, cnt<=1; if len==1 -> OUT, else -> ACCUM.
REQ-015 ACCUM: in_ready=1; on accept, acc<=acc+tree, cnt<=cnt+1; when cnt+1==len -> OUT; no accept -> hold.
REQ-016 OUT: out_valid=1, out_sum=acc, stable until handshake; in_ready=out_ready.
REQ-017 OUT with out_ready=1 and no in_valid -> IDLE, acc<=0, cnt<=0.
REQ-018 OUT with out_ready=1 and in_valid=1: result retired and the beat taken as first beat of next group per REQ-014 in the same cycle (no bubble).
REQ-019 Latency: out_valid asserts the cycle after the last beat of a group is accepted.
REQ-020 cfg_len SHALL be sampled only on the first beat of a group; mid-group changes ignored.
REQ-021 flush=1 in any state: next state IDLE, acc/cnt cleared, out_valid deasserted, pending result dropped; in_ready=0 and no beat accepted that cycle.
REQ-022 Throughput: one beat per cycle sustained, including across group boundaries when out_ready=1.
REQ-023 cnt SHALL never wrap; maximum group length 255 beats.

Reset
REQ-024 rst_n=0 at a rising edge: state IDLE, acc=0, cnt=0, len=1; outputs out_valid=0, out_sum=0, busy=0, in_ready=0 while rst_n=0.
REQ-025 Reset mid-group or in OUT SHALL discard all partial and pending results; first beat after release starts a new group.

Configuration
REQ-026 Macro ADDER_TREE_SAT_EN defined: every acc update (REQ-015) saturates to signed range [-32768, 32767]; out_sum reflects saturated value.
REQ-027 ADDER_TREE_SAT_EN undefined: acc updates wrap mod 2^16; no saturation logic present.

Verification
REQ-028 cfg_len=1, in_data all 1, out_ready=1 -> out_valid next cycle, out_sum=14; in_ready stays 1 every cycle.
REQ-029 cfg_len=3, three back-to-back beats of in_data[i]=i -> out_sum=273 one cycle after third beat; next group's first beat accepted in OUT cycle.
REQ-030 cfg_len=2, out_ready=0 for 5 cycles after result -> out_sum=held, in_ready=0, no beat lost; release -> handshake, IDLE.
REQ-031 cfg_len=4, flush after 2 beats -> IDLE, busy=0, no out_valid; next group of cfg_len=1 with all-2 data gives 28.
REQ-032 cfg_len=4, all lanes 1000 (tree 14000) -> with ADDER_TREE_SAT_EN out_sum=32767; without out_sum=56000 mod 65536 = -9536.
REQ-033 rst_n=0 asserted in ACCUM after 3 of 8 beats -> all outputs zero; after release, cfg_len=1 beat of all 1 gives 14.
